// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 6-stage pipe (pc, if, id, exe, mem, wb).
// Arbitrates mem/exe/id stalls and the exe branch flush; aborts stuck memory accesses.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 stallreq_id_in,
    input  logic                 exe_busy_in,
    input  logic                 mem_req_in,
    input  logic                 mem_ack_in,
    input  logic                 branch_flush_in,
    output logic [5:0]           stall_out,
    output logic [5:0]           flush_out,
    output logic                 bus_err_out,
    output logic [CNT_WIDTH-1:0] stall_cycles_out
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STAGE_W = 6;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_EXE_BUSY
    } state_e;

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 pend_flush_q, pend_flush_d;
    logic                 bus_err_q, bus_err_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAGE_W-1:0]   stall_c, flush_c;
    logic                 timeout_c;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            pend_flush_q <= 1'b0;
            bus_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            pend_flush_q <= pend_flush_d;
            bus_err_q    <= bus_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign timeout_c = (state_q == ST_MEM_WAIT) &&
                       (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ack_in;

    // Fixed-priority arbitration: timeout > mem wait > exe busy > branch flush > id stall.
    always_comb begin
        state_d      = ST_RUN;
        wait_cnt_d   = '0;
        pend_flush_d = pend_flush_q;
        bus_err_d    = 1'b0;
        stall_c      = '0;
        flush_c      = '0;
        if (timeout_c) begin
            flush_c      = STAGE_W'(6'b011110);
            bus_err_d    = 1'b1;
            pend_flush_d = 1'b0;
        end else if (mem_req_in && !mem_ack_in) begin
            stall_c    = STAGE_W'(6'b011111);
            flush_c    = STAGE_W'(6'b010000);
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (branch_flush_in) begin
                pend_flush_d = 1'b1;
            end
        end else if (exe_busy_in) begin
            stall_c = STAGE_W'(6'b001111);
            flush_c = STAGE_W'(6'b001000);
            state_d = ST_EXE_BUSY;
            if (branch_flush_in) begin
                pend_flush_d = 1'b1;
            end
        end else if (branch_flush_in || pend_flush_q) begin
            // The id instruction is squashed, so a coincident id stall is moot.
            flush_c      = STAGE_W'(6'b000110);
            pend_flush_d = 1'b0;
        end else if (stallreq_id_in) begin
            stall_c = STAGE_W'(6'b000111);
            flush_c = STAGE_W'(6'b000100);
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_c != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_out        = reset_in ? stall_c : '0;
    assign flush_out        = reset_in ? flush_c : '0;
    assign bus_err_out      = bus_err_q;
    assign stall_cycles_out = stall_cnt_q;

endmodule
